writeback_arb_l7: RTL and testbench
===================================

WRITEBACK_ARB_L7 -- requirements
Module: writeback_arb_l7

Interface
REQ-001 The block SHALL have parameter p_seq_num_bits, default 5, giving the sequence-number width.
REQ-002 The block SHALL have parameter p_num_pipes, default 2 (legal 1-8), giving the number of execute pipes feeding writeback.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset (rst==0 resets).
REQ-005 The block SHALL have port X_val  input  p_num_pipes  per-pipe X__W message valid.
REQ-006 The block SHALL have port X_rdy  output  p_num_pipes  per-pipe ready; at most one bit high per cycle.
REQ-007 The block SHALL have port X_pc  input  p_num_pipes x 32  per-pipe instruction PC.
REQ-008 The block SHALL have port X_seq_num  input  p_num_pipes x p_seq_num_bits  per-pipe sequence number.
REQ-009 The block SHALL have port X_waddr  input  p_num_pipes x 5  per-pipe destination register.
REQ-010 The block SHALL have port X_wdata  input  p_num_pipes x 32  per-pipe write data.
REQ-011 The block SHALL have port X_wen  input  p_num_pipes  per-pipe write enable.
REQ-012 The block SHALL have port rf_wen, rf_waddr, rf_wdata  output  1/5/32  register-file write port.
REQ-013 The block SHALL have port C_val  output  1  completion message valid.
REQ-014 The block SHALL have port C_rdy  input  1  completion consumer ready.
REQ-015 The block SHALL have port C_pc, C_seq_num  output  32/p_seq_num_bits  completed instruction identity.

Function
REQ-016 Arbitration SHALL be round-robin: grant the first asserted X_val at or after priority pointer ptr, wrapping from p_num_pipes-1 to 0.
REQ-017 X_rdy[g] SHALL be high only for granted pipe g, and only when the output register is empty or firing this cycle (C_val && C_rdy).
REQ-018 X_rdy SHALL not depend combinationally on any X_* data signal other than X_val.
REQ-019 On an accepted transfer (X_val[g] && X_rdy[g]), ptr SHALL become (g+1) mod p_num_pipes; otherwise ptr holds.
REQ-020 Accepted messages SHALL be captured in a one-entry output register; latency from accept to C_val is exactly 1 cycle.
REQ-021 Output register states: EMPTY, FULL; EMPTY->FULL on accept; FULL->EMPTY on fire without accept; FULL->FULL on fire with accept (back-to-back, full throughput) or on stall.
REQ-022 While C_val && !C_rdy, C_pc, C_seq_num and all held data SHALL remain stable.
REQ-023 rf_wen SHALL equal C_val && C_rdy && held wen && (held waddr != 0); x0 writes are suppressed.
REQ-024 rf_waddr and rf_wdata SHALL present held waddr/wdata whenever C_val; value is don't-care otherwise.
REQ-025 Each accepted message SHALL produce exactly one completion and at most one register-file write; no message dropped or duplicated.
REQ-026 With p_num_pipes==1, the block SHALL behave as a single pipeline register with ptr fixed at 0.

Reset
REQ-027 While rst==0 (asserted asynchronously, any cycle), output register SHALL be EMPTY, ptr SHALL be 0, C_val=0, rf_wen=0, X_rdy=0.
REQ-028 A message in flight when reset asserts SHALL be discarded; no rf write or completion occurs for it.
REQ-029 After rst deasserts, the first accept SHALL occur no earlier than the first rising edge with rst==1.

Verification
REQ-030 Single pipe: pipe0 sends pc=0x200, seq=3, waddr=5, wdata=0xDEADBEEF, wen=1, C_rdy=1 -> next cycle C_val=1, rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, C_seq_num=3.
REQ-031 Contention (p_num_pipes=2): both pipes valid for 4 cycles after reset -> grants ordered pipe0,pipe1,pipe0,pipe1; one completion per cycle.
REQ-032 x0/store: waddr=0, wen=1 -> C_val=1, rf_wen=0; waddr=7, wen=0 (sw) -> C_val=1, rf_wen=0.
REQ-033 Backpressure: C_rdy=0 for 3 cycles with FULL register -> X_rdy all 0, outputs stable; C_rdy=1 -> fire plus new accept same cycle.
REQ-034 Reset mid-operation: assert rst=0 between clock edges while FULL -> C_val drops immediately; after release, ptr=0, no stale completion.
REQ-035 Random: random X_val and C_rdy delays (0-3 cycles) across 3 pipes -> completions match a scoreboard of accepted messages exactly, no starvation beyond p_num_pipes-1 grants.

Source files
------------

// File: rtl/writeback_arb_l7.sv
// writeback_arb_l7 -- round-robin writeback arbiter with a one-entry output
// register.
//
// Several execute pipes offer X__W messages (pc, seq_num, waddr, wdata, wen).
// One pipe is granted per cycle, starting the search at a rotating priority
// pointer. The accepted message is held in a single output register. The
// register presents the message as a completion (C_*) and drives the
// register-file write port when the completion fires.
//
// Ports
//   clk, rst        : clock; asynchronous active-low reset
//   X_val / X_rdy   : per-pipe valid / ready (at most one X_rdy bit high)
//   X_pc, X_seq_num,
//   X_waddr, X_wdata,
//   X_wen           : per-pipe message fields, packed with pipe 0 in the LSBs
//   rf_wen/waddr/wdata : register-file write port (x0 writes suppressed)
//   C_val / C_rdy   : completion handshake
//   C_pc, C_seq_num : identity of the completing instruction
module writeback_arb_l7 #(
  parameter int unsigned p_seq_num_bits = 5,
  parameter int unsigned p_num_pipes    = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_pipes-1:0]                X_val,
  output logic [p_num_pipes-1:0]                X_rdy,
  input  logic [p_num_pipes*32-1:0]             X_pc,
  input  logic [p_num_pipes*p_seq_num_bits-1:0] X_seq_num,
  input  logic [p_num_pipes*5-1:0]              X_waddr,
  input  logic [p_num_pipes*32-1:0]             X_wdata,
  input  logic [p_num_pipes-1:0]                X_wen,
  output logic                                  rf_wen,
  output logic [4:0]                            rf_waddr,
  output logic [31:0]                           rf_wdata,
  output logic                                  C_val,
  input  logic                                  C_rdy,
  output logic [31:0]                           C_pc,
  output logic [p_seq_num_bits-1:0]             C_seq_num
);

  localparam int unsigned PtrW = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  typedef enum logic {EMPTY, FULL} state_e;

  state_e                    state_q, state_d;
  logic [PtrW-1:0]           ptr_q,   ptr_d;
  logic [31:0]               pc_q,    pc_d;
  logic [p_seq_num_bits-1:0] seq_q,   seq_d;
  logic [4:0]                waddr_q, waddr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      wen_q,   wen_d;

  logic            gnt_vld;
  logic [PtrW-1:0] gnt_idx;
  logic            can_take;
  logic            accept;
  logic            fire;

  // First asserted X_val at or after ptr_q, wrapping past the last pipe.
  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < p_num_pipes; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= p_num_pipes) idx = idx - p_num_pipes;
      if (!gnt_vld && X_val[PtrW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PtrW'(idx);
      end
    end
  end

  // Ready depends only on X_val (through the grant), register occupancy and
  // C_rdy; gating with rst keeps X_rdy low for the whole reset interval.
  always_comb begin
    int unsigned nxt;
    fire     = (state_q == FULL) && C_rdy;
    can_take = rst && ((state_q == EMPTY) || C_rdy);
    accept   = gnt_vld && can_take;

    X_rdy = '0;
    if (accept) X_rdy[gnt_idx] = 1'b1;

    nxt = 32'(gnt_idx) + 1;
    if (nxt >= p_num_pipes) nxt = 0;
    ptr_d = accept ? PtrW'(nxt) : ptr_q;

    state_d = state_q;
    if (accept)    state_d = FULL;
    else if (fire) state_d = EMPTY;

    pc_d    = pc_q;
    seq_d   = seq_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    if (accept) begin
      pc_d    = X_pc     [32'(gnt_idx)*32 +: 32];
      seq_d   = X_seq_num[32'(gnt_idx)*p_seq_num_bits +: p_seq_num_bits];
      waddr_d = X_waddr  [32'(gnt_idx)*5 +: 5];
      wdata_d = X_wdata  [32'(gnt_idx)*32 +: 32];
      wen_d   = X_wen    [gnt_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      pc_q    <= '0;
      seq_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pc_q    <= pc_d;
      seq_q   <= seq_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
    end
  end

  assign C_val     = (state_q == FULL);
  assign C_pc      = pc_q;
  assign C_seq_num = seq_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign rf_wen    = fire && wen_q && (waddr_q != 5'd0);

endmodule

// File: tb/tb_writeback_arb_l7.sv
module tb_writeback_arb_l7;
  localparam int N  = 3;
  localparam int SW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      X_val = '0;
  logic [N-1:0]      X_rdy;
  logic [N*32-1:0]   X_pc = '0;
  logic [N*SW-1:0]   X_seq_num = '0;
  logic [N*5-1:0]    X_waddr = '0;
  logic [N*32-1:0]   X_wdata = '0;
  logic [N-1:0]      X_wen = '0;
  logic              rf_wen;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic              C_val;
  logic              C_rdy = 1'b0;
  logic [31:0]       C_pc;
  logic [SW-1:0]     C_seq_num;

  int checks = 0;
  int errors = 0;

  writeback_arb_l7 #(.p_seq_num_bits(SW), .p_num_pipes(N)) dut (
    .clk(clk), .rst(rst),
    .X_val(X_val), .X_rdy(X_rdy), .X_pc(X_pc), .X_seq_num(X_seq_num),
    .X_waddr(X_waddr), .X_wdata(X_wdata), .X_wen(X_wen),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .C_val(C_val), .C_rdy(C_rdy), .C_pc(C_pc), .C_seq_num(C_seq_num)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [31:0] pc, input logic [SW-1:0] seq,
                       input logic [4:0] wa, input logic [31:0] wd, input logic we);
    X_pc[p*32 +: 32]     = pc;
    X_seq_num[p*SW +: SW] = seq;
    X_waddr[p*5 +: 5]    = wa;
    X_wdata[p*32 +: 32]  = wd;
    X_wen[p]             = we;
  endtask

  task automatic do_reset();
    step();
    rst   = 1'b0;
    X_val = '1;
    repeat (2) step();
    rst   = 1'b1;
    X_val = '0;
  endtask

  // Reference model: a queue holding at most one accepted message and an
  // integer priority pointer; outputs derived from the arbitration rules.
  typedef struct {
    logic [31:0]   pc;
    logic [SW-1:0] seq;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic          wen;
  } msg_t;

  msg_t         held[$];
  int           m_ptr = 0;
  int           g;
  bit           can;
  logic [N-1:0] exp_rdy;
  msg_t         m;

  always @(negedge clk) begin
    if (!rst) begin
      held.delete();
      m_ptr = 0;
      chk("rst_x_rdy", X_rdy, 0);
      chk("rst_c_val", C_val, 0);
      chk("rst_rf_wen", rf_wen, 0);
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && X_val[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      can     = (held.size() == 0) || C_rdy;
      exp_rdy = '0;
      if (g >= 0 && can) exp_rdy[g] = 1'b1;
      chk("m_x_rdy", X_rdy, exp_rdy);
      chk("m_c_val", C_val, held.size() != 0);
      if (held.size() != 0) begin
        chk("m_c_pc", C_pc, held[0].pc);
        chk("m_c_seq", C_seq_num, held[0].seq);
        chk("m_rf_waddr", rf_waddr, held[0].waddr);
        chk("m_rf_wdata", rf_wdata, held[0].wdata);
        chk("m_rf_wen", rf_wen, C_rdy && held[0].wen && held[0].waddr != 0);
        if (C_rdy) void'(held.pop_front());
      end else begin
        chk("m_rf_wen_idle", rf_wen, 0);
      end
      if (exp_rdy != 0) begin
        m.pc    = X_pc[g*32 +: 32];
        m.seq   = X_seq_num[g*SW +: SW];
        m.waddr = X_waddr[g*5 +: 5];
        m.wdata = X_wdata[g*32 +: 32];
        m.wen   = X_wen[g];
        held.push_back(m);
        m_ptr = (g + 1) % N;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] grant_exp [4];
  int           wait_cnt [N];
  int           dly [N];
  int           stall;
  int           n_acc, n_fire;
  logic [N-1:0] acc;

  initial begin
    grant_exp[0] = 3'b001; grant_exp[1] = 3'b010;
    grant_exp[2] = 3'b001; grant_exp[3] = 3'b010;

    do_reset();
    @(negedge clk);
    chk("post_rst_c_val", C_val, 0);

    // Single message through pipe 0
    drive(0, 32'h200, 5'd3, 5'd5, 32'hDEADBEEF, 1'b1);
    X_val = 3'b001; C_rdy = 1'b1;
    @(negedge clk); chk("t1_x_rdy", X_rdy, 3'b001);
    step(); X_val = '0;
    @(negedge clk);
    chk("t1_c_val", C_val, 1);
    chk("t1_rf_wen", rf_wen, 1);
    chk("t1_rf_waddr", rf_waddr, 5);
    chk("t1_rf_wdata", rf_wdata, 32'hDEADBEEF);
    chk("t1_c_seq", C_seq_num, 3);
    chk("t1_c_pc", C_pc, 32'h200);
    step();

    // Contention between pipes 0 and 1 right after reset
    do_reset();
    for (int p = 0; p < N; p++) drive(p, 32'h1000 + p * 4, SW'(p + 8), 5'(p + 1), 32'hA0 + p, 1'b1);
    X_val = 3'b011; C_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("cont_grant", X_rdy, grant_exp[c]);
      if (c > 0) begin
        chk("cont_c_val", C_val, 1);
        chk("cont_c_pc", C_pc, (c % 2 == 1) ? 32'h1000 : 32'h1004);
      end
      step();
    end
    X_val = '0;
    @(negedge clk); chk("cont_last_pc", C_pc, 32'h1004);
    step();

    // x0 write and store (wen=0) both complete without a register write
    drive(0, 32'h300, 5'd1, 5'd0, 32'h11, 1'b1);
    X_val = 3'b001;
    @(negedge clk); chk("x0_x_rdy", X_rdy, 3'b001);
    step();
    drive(0, 32'h304, 5'd2, 5'd7, 32'h22, 1'b0);
    @(negedge clk);
    chk("x0_c_val", C_val, 1); chk("x0_rf_wen", rf_wen, 0); chk("x0_c_pc", C_pc, 32'h300);
    step(); X_val = '0;
    @(negedge clk);
    chk("sw_c_val", C_val, 1); chk("sw_rf_wen", rf_wen, 0);
    chk("sw_c_pc", C_pc, 32'h304); chk("sw_rf_waddr", rf_waddr, 7);
    step();

    // Backpressure with a full register
    C_rdy = 1'b0;
    drive(1, 32'h400, 5'd4, 5'd9, 32'h44, 1'b1);
    X_val = 3'b010;
    @(negedge clk); chk("bp_x_rdy0", X_rdy, 3'b010);
    step();
    drive(2, 32'h500, 5'd5, 5'd10, 32'h55, 1'b1);
    X_val = 3'b100;
    repeat (3) begin
      @(negedge clk);
      chk("bp_x_rdy", X_rdy, 0); chk("bp_c_val", C_val, 1);
      chk("bp_c_pc", C_pc, 32'h400); chk("bp_rf_wdata", rf_wdata, 32'h44);
      chk("bp_rf_wen", rf_wen, 0);
      step();
    end
    C_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", X_rdy, 3'b100); chk("bp_release_pc", C_pc, 32'h400);
    chk("bp_release_wen", rf_wen, 1);
    step(); X_val = '0;
    @(negedge clk); chk("bp_next_pc", C_pc, 32'h500);
    step();

    // Reset asserted between edges while the register is full
    C_rdy = 1'b0;
    drive(1, 32'h600, 5'd6, 5'd11, 32'h66, 1'b1);
    X_val = 3'b010;
    @(negedge clk); chk("mr_x_rdy", X_rdy, 3'b010);
    step(); X_val = '0;
    #2 rst = 1'b0;
    #1 chk("mr_c_val_drop", C_val, 0); chk("mr_rf_wen", rf_wen, 0);
    step(); step();
    rst = 1'b1; C_rdy = 1'b1;
    for (int p = 0; p < N; p++) drive(p, 32'h700 + p * 4, SW'(p), 5'(p + 12), 32'h70 + p, 1'b1);
    X_val = 3'b111;
    @(negedge clk); chk("mr_ptr0_grant", X_rdy, 3'b001);
    step(); X_val = '0;
    @(negedge clk); chk("mr_new_pc", C_pc, 32'h700);
    step();

    // Randomised traffic on all pipes with random completion stalls
    do_reset();
    for (int p = 0; p < N; p++) begin wait_cnt[p] = 0; dly[p] = $urandom_range(0, 3); end
    stall = 0; n_acc = 0; n_fire = 0; C_rdy = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc = X_val & X_rdy;
      if (C_val && C_rdy) n_fire++;
      for (int p = 0; p < N; p++) begin
        if (acc[p]) begin
          n_acc++;
          chk("starve", wait_cnt[p] <= N - 1, 1);
          wait_cnt[p] = 0;
        end else if (X_val[p] && acc != 0) begin
          wait_cnt[p]++;
        end
      end
      step();
      for (int p = 0; p < N; p++) begin
        if (acc[p]) begin
          X_val[p] = 1'b0;
          dly[p] = $urandom_range(0, 3);
        end
        if (!X_val[p]) begin
          if (dly[p] == 0) begin
            drive(p, $urandom, SW'($urandom), 5'($urandom_range(0, 31) & ((($urandom & 3) == 0) ? 0 : 31)),
                  $urandom, 1'($urandom));
            X_val[p] = 1'b1;
          end else begin
            dly[p]--;
          end
        end
      end
      if (stall > 0) begin
        C_rdy = 1'b0; stall--;
      end else begin
        C_rdy = 1'b1;
        if ($urandom_range(0, 3) == 0) stall = $urandom_range(0, 3);
      end
    end
    X_val = '0; C_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (C_val && C_rdy) n_fire++;
      step();
    end
    chk("conservation", n_fire, n_acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
